// File: rtl/request_serializer_pkg.sv
// Shared constants, FSM state type and bit-vector helpers for the request serializer.
// Any block that needs the request/index widths imports these definitions from here.
package request_serializer_pkg;

   localparam int REQ_W = 16;
   localparam int IDX_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // The power-of-two trick gives a cheap one-hot test without counting the set bits.
   function automatic logic single_bit(input logic [REQ_W-1:0] v);
      return (v != '0) && ((v & (v - REQ_W'(1))) == '0);
   endfunction

   function automatic logic [REQ_W-1:0] idx_mask(input logic [IDX_W-1:0] idx);
      logic [REQ_W-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/prio_enc_16x4.sv
// Combinational 16-to-4 priority encoder from the encoder family.
// LSB_FIRST selects the lowest set bit, otherwise the highest set bit wins.
module prio_enc_16x4 #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic [15:0] req,
   output logic [3:0]  idx,
   output logic        found
);

   // The scan direction is the reverse of the priority, so the winning bit is written last.
   always_comb begin
      idx   = 4'd0;
      found = 1'b0;
      if (LSB_FIRST) begin
         for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
               idx   = 4'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (req[i]) begin
               idx   = 4'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/request_serializer.sv
// Accepts a multi-hot request vector and emits the index of each set bit, one per
// output transfer, in priority order set by LSB_FIRST.
module request_serializer
   import request_serializer_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out,
   output logic        out_last,
   output logic        busy
);

   state_e             state_q, state_d;
   logic [REQ_W-1:0]   pending_q, pending_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [IDX_W-1:0]   sel_idx;
   logic               sel_found;
   logic               last_w;

   prio_enc_16x4 #(
      .LSB_FIRST (LSB_FIRST)
   ) u_prio_enc (
      .req   (pending_q),
      .idx   (sel_idx),
      .found (sel_found)
   );

   // Index and last flag come only from the registered pending vector, so they hold during stalls.
   assign last_w    = out_valid_q && single_bit(pending_q);
   assign out       = (out_valid_q && sel_found) ? sel_idx : '0;
   assign out_last  = last_w;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && (in != '0)) begin
               pending_d = in;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (out_ready) begin
               pending_d = pending_q & ~idx_mask(sel_idx);
               if (last_w) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
      // Handshake flags are registered from the next state so they line up with state_q.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == BUSY);
      busy_d      = (state_d == BUSY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_request_serializer.sv
// Scoreboard bench driving an LSB-first and an MSB-first serializer with identical stimulus;
// expected index streams come from a set-bit list model, checked by a negedge monitor.
module tb_request_serializer;

   typedef struct {
      logic [3:0] idx;
      logic       last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_vec;
   logic        out_ready;

   logic        in_ready_l, out_valid_l, out_last_l, busy_l;
   logic [3:0]  out_l;
   logic        in_ready_m, out_valid_m, out_last_m, busy_m;
   logic [3:0]  out_m;

   int          nVectors;
   int          nMiscompares;
   int          remaining;
   exp_t        exp_lsb[$];
   exp_t        exp_msb[$];

   request_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_l),
      .in        (in_vec),
      .out_valid (out_valid_l),
      .out_ready (out_ready),
      .out       (out_l),
      .out_last  (out_last_l),
      .busy      (busy_l)
   );

   request_serializer #(.LSB_FIRST(1'b0)) dut_msb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_m),
      .in        (in_vec),
      .out_valid (out_valid_m),
      .out_ready (out_ready),
      .out       (out_m),
      .out_last  (out_last_m),
      .busy      (busy_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and hold for one full cycle.
   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
      in_valid  = v;
      in_vec    = d;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle();
      for (int k = 0; k < 100 && remaining != 0; k++) begin
         applyStimulus(1'b0, 16'h0, 1'b1);
      end
      if (remaining != 0) begin
         nMiscompares++;
         $display("[TB] FAIL drain_timeout: remaining %0d, expected 0", remaining);
      end
      applyStimulus(1'b0, 16'h0, 1'b1);
   endtask

   task automatic checkIdleNow(input string tag);
      checkOutput({tag, "_lsb_valid"}, out_valid_l, 1'b0);
      checkOutput({tag, "_lsb_out"},   out_l,       4'd0);
      checkOutput({tag, "_lsb_last"},  out_last_l,  1'b0);
      checkOutput({tag, "_lsb_busy"},  busy_l,      1'b0);
      checkOutput({tag, "_lsb_ready"}, in_ready_l,  1'b1);
      checkOutput({tag, "_msb_valid"}, out_valid_m, 1'b0);
      checkOutput({tag, "_msb_out"},   out_m,       4'd0);
      checkOutput({tag, "_msb_busy"},  busy_m,      1'b0);
   endtask

   // Reference model: an accepted vector becomes its list of set-bit indices, in both orders.
   always @(posedge clk) begin
      if (!rst_n) begin
         remaining = 0;
         exp_lsb.delete();
         exp_msb.delete();
      end else if (remaining != 0) begin
         if (out_ready) remaining--;
      end else if (in_valid && in_vec != 16'h0) begin
         int n;
         int k;
         n = $countones(in_vec);
         k = 0;
         for (int i = 0; i < 16; i++) begin
            if (in_vec[i]) begin
               exp_lsb.push_back('{idx: 4'(i), last: (k == n - 1)});
               k++;
            end
         end
         k = 0;
         for (int i = 15; i >= 0; i--) begin
            if (in_vec[i]) begin
               exp_msb.push_back('{idx: 4'(i), last: (k == n - 1)});
               k++;
            end
         end
         remaining = n;
      end
   end

   // Monitor: compares handshake flags every cycle and pops an index on each output transfer.
   always @(negedge clk) begin
      logic ev;
      ev = rst_n && (remaining != 0);
      checkOutput("lsb_out_valid", out_valid_l, ev);
      checkOutput("lsb_busy",      busy_l,      ev);
      checkOutput("lsb_in_ready",  in_ready_l,  !ev);
      checkOutput("msb_out_valid", out_valid_m, ev);
      checkOutput("msb_busy",      busy_m,      ev);
      checkOutput("msb_in_ready",  in_ready_m,  !ev);
      if (ev) begin
         if (exp_lsb.size() == 0 || exp_msb.size() == 0) begin
            nMiscompares++;
            $display("[TB] FAIL scoreboard_empty: lsb %0d, msb %0d entries, expected nonzero",
                     exp_lsb.size(), exp_msb.size());
         end else begin
            checkOutput("lsb_out",  out_l,      exp_lsb[0].idx);
            checkOutput("lsb_last", out_last_l, exp_lsb[0].last);
            checkOutput("msb_out",  out_m,      exp_msb[0].idx);
            checkOutput("msb_last", out_last_m, exp_msb[0].last);
            if (out_ready) begin
               void'(exp_lsb.pop_front());
               void'(exp_msb.pop_front());
            end
         end
      end else begin
         checkOutput("lsb_idle_out",  out_l,      4'd0);
         checkOutput("lsb_idle_last", out_last_l, 1'b0);
         checkOutput("msb_idle_out",  out_m,      4'd0);
         checkOutput("msb_idle_last", out_last_m, 1'b0);
      end
   end

   initial begin
      int busyCount;
      nVectors     = 0;
      nMiscompares = 0;
      remaining    = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_vec       = 16'h0;
      out_ready    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkIdleNow("reset");
      rst_n = 1'b1;

      // Single bit vector
      applyStimulus(1'b1, 16'h0001, 1'b1);
      waitIdle();

      // Sparse vector at full throughput
      applyStimulus(1'b1, 16'h8421, 1'b1);
      waitIdle();

      // Full vector with out_ready alternating, starting ready on the first busy cycle
      applyStimulus(1'b1, 16'hFFFF, 1'b1);
      busyCount = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy_l) busyCount++;
         applyStimulus(1'b0, 16'h0, (k % 2) == 0);
      end
      checkOutput("ffff_busy_cycles", 16'(busyCount), 16'd31);
      waitIdle();

      // Zero vector is swallowed; vectors presented while busy are ignored
      applyStimulus(1'b1, 16'h0000, 1'b1);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b1, 16'h0003, 1'b0);
      applyStimulus(1'b1, 16'h0F00, 1'b0);
      applyStimulus(1'b1, 16'h0F00, 1'b1);
      applyStimulus(1'b1, 16'h0F00, 1'b0);
      waitIdle();

      // Reset in the middle of a vector
      applyStimulus(1'b1, 16'h00F0, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b1);
      rst_n = 1'b0;
      #1;
      checkIdleNow("midreset");
      applyStimulus(1'b0, 16'h0, 1'b1);
      rst_n = 1'b1;
      applyStimulus(1'b1, 16'h0002, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b1);
      waitIdle();

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         logic [15:0] d;
         d = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
         applyStimulus($urandom_range(0, 2) != 0, d, $urandom_range(0, 3) != 0);
      end
      waitIdle();

      checkOutput("lsb_queue_empty", 16'(exp_lsb.size()), 16'd0);
      checkOutput("msb_queue_empty", 16'(exp_msb.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/request_serializer.md
REQUEST_SERIALIZER -- requirements
Module: request_serializer

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1, where 1 serves the lowest set bit index first and 0 serves the highest first.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all flops update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, indicating that a request vector is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit, indicating that the block accepts a vector this cycle.
REQ-006 The block SHALL have port in, input, 16 bits, the multi-hot request vector.
REQ-007 The block SHALL have port out_valid, output, 1 bit, indicating that out holds a valid index.
REQ-008 The block SHALL have port out_ready, input, 1 bit, indicating that downstream consumes the index this cycle.
REQ-009 The block SHALL have port out, output, 4 bits, the binary index of the selected request bit.
REQ-010 The block SHALL have port out_last, output, 1 bit, indicating that out is the final index of the current vector.
REQ-011 The block SHALL have port busy, output, 1 bit, indicating that the state is BUSY.

Function
REQ-012 The block SHALL hold a 16-bit pending register and a 2-state FSM with states IDLE and BUSY.
REQ-013 In IDLE, the block SHALL drive in_ready=1, out_valid=0 and busy=0.
REQ-014 In BUSY, the block SHALL drive in_ready=0, out_valid=1 and busy=1.
REQ-015 On the IDLE transfer (in_valid & in_ready) with in!=0, the block SHALL load pending<=in and move to BUSY; out_valid SHALL rise 1 cycle after acceptance.
REQ-016 On the IDLE transfer with in==0, the block SHALL accept and drop the vector, stay in IDLE, and produce no output.
REQ-017 In BUSY, out SHALL be the index of the lowest set pending bit when LSB_FIRST=1, or the highest set pending bit when LSB_FIRST=0, decoded from registered pending only.
REQ-018 out_last SHALL be 1 iff pending has exactly one bit set, and SHALL be 0 in IDLE.
REQ-019 On an output transfer (out_valid & out_ready), the block SHALL clear the selected bit in pending; if out_last=1, the block SHALL move to IDLE in the same edge.
REQ-020 While out_ready=0 in BUSY, out, out_last and pending SHALL hold stable.
REQ-021 A vector with N set bits SHALL yield exactly N output transfers, one per cycle at full throughput; in_ready SHALL return to 1 on the cycle after the last transfer.
REQ-022 in_valid and in presented while in BUSY SHALL be ignored, and no state change SHALL result.
REQ-023 out SHALL be 4'd0 whenever out_valid=0.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, pending=16'h0000, out_valid=0, out=4'd0, out_last=0, busy=0 and in_ready=1 (once deasserted).
REQ-025 Reset asserted mid-vector SHALL discard all remaining pending bits, and no output SHALL follow after release.
REQ-026 Release of rst_n SHALL be synchronous to clk; the first transfer SHALL be possible on the first rising edge after release.

Structure
REQ-027 A shared package SHALL hold the constants REQ_W=16 and IDX_W=4 and the state enum {IDLE, BUSY}.
REQ-028 The priority selection SHALL be one combinational sub-module, prio_enc_16x4 (16-bit in, 4-bit index out, direction parameter), reused from the encoder family.
REQ-029 The one-bit-set test for out_last SHALL be computed as (pending & (pending-1))==0 with pending!=0, not as a full popcount.

Verification
REQ-030 Scenario: in=16'h0001 with in_valid=1 and out_ready=1 -> out=0 and out_last=1 for 1 cycle, then in_ready=1.
REQ-031 Scenario: in=16'h8421 with LSB_FIRST=1 and out_ready held at 1 -> out sequence 0,5,10,15 on consecutive cycles, with out_last only on 15.
REQ-032 Scenario: the same vector with LSB_FIRST=0 -> out sequence 15,10,5,0.
REQ-033 Scenario: in=16'hFFFF with out_ready toggling 1,0 -> 16 transfers 0..15 with out stable during stall cycles, and busy high for 31 cycles.
REQ-034 Scenario: in=16'h0000 with in_valid=1 -> accepted, out_valid stays 0, state remains IDLE; a BUSY-time in_valid with in=16'h0F00 is ignored.
REQ-035 Scenario: rst_n pulsed low after 2 of 4 transfers of 16'h00F0 -> outputs clear immediately, no further out_valid, and a new vector 16'h0002 then yields out=1.
